// File: rtl/truth_table_checker.sv
// Exhaustive truth-table sweeper: walks every input vector of a small combinational DUT,
// captures its response and scores it against a golden table.
module truth_table_checker #(
  parameter int NUM_IN = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter logic [(1<<NUM_IN)-1:0] EXPECTED = 16'hF888
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     y_in,
  output logic [NUM_IN-1:0]        vec_out,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [(1<<NUM_IN)-1:0]   table_out,
  output logic [NUM_IN:0]          mismatch_cnt,
  output logic [NUM_IN-1:0]        first_fail
);

  localparam int NV = 1 << NUM_IN;
  localparam int HW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [HW-1:0]     HOLD_LAST = HW'(SETTLE_CYCLES - 1);
  localparam logic [NUM_IN-1:0] VEC_LAST  = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [NUM_IN-1:0]   vec_q, vec_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [NV-1:0]       table_q, table_d;
  logic [NUM_IN:0]     mcnt_q, mcnt_d;
  logic [NUM_IN-1:0]   ff_q, ff_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                miss;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    table_d = table_q;
    mcnt_d  = mcnt_q;
    ff_d    = ff_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    miss    = y_in != EXPECTED[vec_q];

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          vec_d   = '0;
          hold_d  = '0;
          table_d = '0;
          mcnt_d  = '0;
          ff_d    = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 1'b1;
        end else begin
          // Sample edge: the vector has been stable for SETTLE_CYCLES edges.
          table_d[vec_q] = y_in;
          if (miss) begin
            mcnt_d = mcnt_q + 1'b1;
            if (mcnt_q == '0) ff_d = vec_q;
          end
          hold_d = '0;
          if (vec_q == VEC_LAST) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (mcnt_q == '0) && !miss;
            vec_d   = '0;
          end else begin
            vec_d = vec_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      hold_q  <= '0;
      table_q <= '0;
      mcnt_q  <= '0;
      ff_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      table_q <= table_d;
      mcnt_q  <= mcnt_d;
      ff_q    <= ff_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign vec_out      = vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign table_out    = table_q;
  assign mismatch_cnt = mcnt_q;
  assign first_fail   = ff_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Scoreboard bench: the driver pushes expected sweep results, monitors pop them when done rises.
module tb_truth_table_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start4 = 1'b0;
  logic start2 = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT-under-test models: y is a lookup of the current stimulus vector
  logic [15:0] lut4 = '0;
  logic [3:0]  lut2 = '0;

  logic [3:0]  vec4;  logic busy4, done4, pass4;
  logic [15:0] tbl4;  logic [4:0] mc4; logic [3:0] ff4;
  logic [1:0]  vec2;  logic busy2, done2, pass2;
  logic [3:0]  tbl2;  logic [2:0] mc2; logic [1:0] ff2;
  logic        y4, y2;
  assign y4 = lut4[vec4];
  assign y2 = lut2[vec2];

  truth_table_checker dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .y_in(y4), .vec_out(vec4),
    .busy(busy4), .done(done4), .pass(pass4), .table_out(tbl4),
    .mismatch_cnt(mc4), .first_fail(ff4));

  truth_table_checker #(.NUM_IN(2), .SETTLE_CYCLES(1), .EXPECTED(4'h8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .y_in(y2), .vec_out(vec2),
    .busy(busy2), .done(done2), .pass(pass2), .table_out(tbl2),
    .mismatch_cnt(mc2), .first_fail(ff2));

  typedef struct {
    logic [15:0] tbl;
    logic        pass;
    int          mcnt;
    int          ff;
    int          start_edge;
  } exp_t;

  exp_t q4[$];
  exp_t q2[$];
  int errors = 0;
  int checks = 0;
  int sweep_start4 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: the captured table is the DUT's function; score it bit by bit against golden.
  function automatic exp_t model(input int nin, input logic [15:0] golden,
                                 input logic [15:0] lut, input int se);
    exp_t e;
    e.tbl = '0; e.mcnt = 0; e.ff = 0; e.start_edge = se;
    for (int v = 0; v < (1 << nin); v++) begin
      e.tbl[v] = lut[v];
      if (lut[v] != golden[v]) begin
        if (e.mcnt == 0) e.ff = v;
        e.mcnt++;
      end
    end
    e.pass = (e.mcnt == 0);
    return e;
  endfunction

  function automatic logic [15:0] ab_or_cd();
    logic [15:0] t;
    for (int v = 0; v < 16; v++) begin
      logic [3:0] b;
      b = v[3:0];
      t[v] = (b[3] & b[2]) | (b[1] & b[0]);
    end
    return t;
  endfunction

  // Monitor for the default-parameter instance
  initial begin
    logic prev_done = 1'b0, prev_busy = 1'b0;
    int busy_cnt = 0;
    int k;
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy4 && !prev_busy) busy_cnt = 0;
      if (busy4) begin
        busy_cnt++;
        k = cyc - sweep_start4;
        check("vec_step", 32'(vec4), 32'(k / 4));
      end
      if (done4 && !prev_done) begin
        if (q4.size() == 0) begin
          check("unexpected_done4", 32'(done4), 32'd0);
        end else begin
          e = q4.pop_front();
          check("latency4", 32'(cyc - e.start_edge), 32'd64);
          check("busy_len4", 32'(busy_cnt), 32'd64);
          check("busy_low4", 32'(busy4), 32'd0);
          check("vec_zero4", 32'(vec4), 32'd0);
          check("table4", 32'(tbl4), 32'(e.tbl));
          check("pass4", 32'(pass4), 32'(e.pass));
          check("mcnt4", 32'(mc4), 32'(e.mcnt));
          check("first_fail4", 32'(ff4), 32'(e.ff));
        end
      end
      prev_done = done4;
      prev_busy = busy4;
    end
  end

  // Monitor for the 2-input, 1-cycle-settle instance
  initial begin
    logic prev_done = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (done2 && !prev_done) begin
        if (q2.size() == 0) begin
          check("unexpected_done2", 32'(done2), 32'd0);
        end else begin
          e = q2.pop_front();
          check("latency2", 32'(cyc - e.start_edge), 32'd4);
          check("table2", 32'(tbl2), 32'(e.tbl));
          check("pass2", 32'(pass2), 32'(e.pass));
          check("mcnt2", 32'(mc2), 32'(e.mcnt));
          check("first_fail2", 32'(ff2), 32'(e.ff));
        end
      end
      prev_done = done2;
    end
  end

  task automatic launch4(input logic [15:0] lut);
    lut4 = lut;
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk); #1;
    sweep_start4 = cyc;
    q4.push_back(model(4, 16'hF888, lut, cyc));
    start4 = 1'b0;
  endtask

  task automatic launch2(input logic [3:0] lut);
    lut2 = lut;
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk); #1;
    q2.push_back(model(2, 16'h0008, {12'h0, lut}, cyc));
    start2 = 1'b0;
  endtask

  task automatic wait_done4(input int budget);
    int n = 0;
    while (!done4 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("done4_seen", 32'(done4), 32'd1);
  endtask

  task automatic wait_done2(input int budget);
    int n = 0;
    while (!done2 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("done2_seen", 32'(done2), 32'd1);
  endtask

  task automatic check_zero4(input string tag);
    check({tag, "_vec"}, 32'(vec4), 32'd0);
    check({tag, "_busy"}, 32'(busy4), 32'd0);
    check({tag, "_done"}, 32'(done4), 32'd0);
    check({tag, "_pass"}, 32'(pass4), 32'd0);
    check({tag, "_table"}, 32'(tbl4), 32'd0);
    check({tag, "_mcnt"}, 32'(mc4), 32'd0);
    check({tag, "_ff"}, 32'(ff4), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] l;
    int n;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero4("reset");
    check("reset2_done", 32'(done2), 32'd0);
    check("reset2_table", 32'(tbl2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Golden DUT (a&b)|(c&d); done must then hold while start stays low
    launch4(ab_or_cd());
    wait_done4(80);
    l = tbl4;
    repeat (3) @(posedge clk);
    #1;
    check("done_hold", 32'(done4), 32'd1);
    check("table_hold", 32'(tbl4), 32'(l));

    // Stuck-at-0 DUT
    launch4(16'h0000);
    wait_done4(80);

    // Reset when vec_out reaches 9 aborts the sweep
    launch4(16'(~32'(ab_or_cd())));
    n = 0;
    while (vec4 != 4'd9 && n < 80) begin
      @(posedge clk); #1;
      n++;
    end
    check("reached_vec9", 32'(vec4), 32'd9);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_zero4("abort");
    q4.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (70) @(posedge clk);
    #1;
    check("no_done_after_abort", 32'(done4), 32'd0);
    launch4(ab_or_cd());
    wait_done4(80);

    // start held high through RUN, relaunch from DONE
    lut4 = 16'($urandom());
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk); #1;
    sweep_start4 = cyc;
    q4.push_back(model(4, 16'hF888, lut4, cyc));
    wait_done4(80);
    @(posedge clk); #1;
    check("relaunch_busy", 32'(busy4), 32'd1);
    check("relaunch_done", 32'(done4), 32'd0);
    check("relaunch_table", 32'(tbl4), 32'd0);
    check("relaunch_mcnt", 32'(mc4), 32'd0);
    sweep_start4 = cyc;
    lut4 = 16'($urandom());
    q4.push_back(model(4, 16'hF888, lut4, cyc));
    start4 = 1'b0;
    wait_done4(80);

    // Randomised DUTs: fully random or near-golden with a few flipped bits
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        l = 16'($urandom());
      end else begin
        l = 16'hF888;
        n = $urandom_range(0, 2);
        for (int f = 0; f < n; f++) l[$urandom_range(0, 15)] ^= 1'b1;
      end
      repeat ($urandom_range(0, 5)) @(posedge clk);
      launch4(l);
      wait_done4(80);
    end

    // Two-input instance: a&b, stuck-at-0, random
    launch2(4'h8);
    wait_done2(10);
    launch2(4'h0);
    wait_done2(10);
    for (int it = 0; it < 4; it++) begin
      launch2(4'($urandom()));
      wait_done2(10);
    end

    repeat (5) @(posedge clk);
    #1;
    check("q4_drained", 32'(q4.size()), 32'd0);
    check("q2_drained", 32'(q2.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
